// File: rtl/cube_root_pkg.sv
// Shared types and constants for the cube root unit and its shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cube_root_pkg;

  // Default operand width; the result width is always a third of it.
  localparam int IN_W_DEF = 24;

  // Multiplier operand width and its fixed iteration count.
  localparam int MUL_W      = 8;
  localparam int MUL_CYCLES = 8;
  localparam int MUL_CNT_W  = $clog2(MUL_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_MUL   = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // Trial term 3*p + 1, where p = y*(y+1) for the candidate y; two guard bits cover the x3.
  function automatic logic [2*MUL_W+1:0] trial_term(input logic [2*MUL_W-1:0] p);
    logic [2*MUL_W+1:0] pe;
    pe = {2'b00, p};
    return (pe << 1) + pe + (2*MUL_W+2)'(1);
  endfunction

endpackage

// File: rtl/cube_root_mult8.sv
// 8x8 -> 16 unsigned shift-add multiplier, one partial product per cycle.
// Latency: busy_o high for exactly MUL_CYCLES cycles after the start edge; y_bo valid once busy_o drops.
// Backpressure: start_i is ignored while busy; no queueing.
module cube_root_mult8
  import cube_root_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [MUL_W-1:0]   a_bi,
  input  logic [MUL_W-1:0]   b_bi,
  input  logic               start_i,
  output logic               busy_o,
  output logic [2*MUL_W-1:0] y_bo
);

  localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(MUL_CYCLES - 1);

  logic                 busy_q,   busy_d;
  logic [MUL_CNT_W-1:0] cnt_q,    cnt_d;
  logic [2*MUL_W-1:0]   mcand_q,  mcand_d;
  logic [2*MUL_W-1:0]   acc_q,    acc_d;
  logic [MUL_W-1:0]     mplier_q, mplier_d;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (!busy_q) begin
      if (start_i) begin
        busy_d   = 1'b1;
        cnt_d    = '0;
        acc_d    = '0;
        mcand_d  = {{MUL_W{1'b0}}, a_bi};
        mplier_d = b_bi;
      end
    end else begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + MUL_CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
      end
    end
  end

  // Multiplier state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  assign busy_o = busy_q;
  assign y_bo   = acc_q;

endmodule

// File: rtl/cube_root.sv
// Sequential floor cube root of an IN_W-bit operand, one result bit per 10-cycle iteration.
// Latency: busy_o high for 80 cycles after the accepting edge; y_bo updates as busy_o falls.
// Backpressure: start_i only sampled while idle; requests during a run are dropped.
module cube_root
  import cube_root_pkg::*;
#(
  parameter int IN_W = IN_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IN_W-1:0]   a_bi,
  input  logic              start_i,
  output logic              busy_o,
  output logic [IN_W/3-1:0] y_bo
);

  localparam int OUT_W = IN_W / 3;
  localparam int S_W   = $clog2(IN_W);
  localparam logic [MUL_CNT_W-1:0] MUL_LAST = MUL_CNT_W'(MUL_CYCLES - 1);

  state_t               state_q,   state_d;
  logic                 busy_q,    busy_d;
  logic [IN_W-1:0]      x_q,       x_d;
  logic [OUT_W-1:0]     y_q,       y_d;
  logic [S_W-1:0]       s_q,       s_d;
  logic [OUT_W-1:0]     y_out_q,   y_out_d;
  logic [MUL_CNT_W-1:0] mul_cnt_q, mul_cnt_d;

  logic                 mul_start;
  logic                 mul_busy;
  logic [MUL_W-1:0]     mul_a;
  logic [MUL_W-1:0]     mul_b;
  logic [2*MUL_W-1:0]   mul_p;

  logic [IN_W-1:0]      t_ext;
  logic [IN_W-1:0]      x_shr;
  logic                 take;
  logic [OUT_W-1:0]     y_inc;

  // y is below 2^(OUT_W-1) whenever SETUP runs, so the doubled operands fit MUL_W bits.
  assign mul_start = (state_q == ST_SETUP);
  assign mul_a     = MUL_W'({y_q, 1'b0});
  assign mul_b     = MUL_W'({y_q, 1'b1});

  cube_root_mult8 u_mult (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (mul_a),
    .b_bi    (mul_b),
    .start_i (mul_start),
    .busy_o  (mul_busy),
    .y_bo    (mul_p)
  );

  // Compare the shifted-down remainder against the trial term so no shift exceeds IN_W bits.
  assign t_ext = IN_W'(trial_term(mul_p));
  assign x_shr = x_q >> s_q;
  assign take  = (x_shr >= t_ext);
  assign y_inc = take ? (y_q + OUT_W'(1)) : y_q;

  // Next-state logic: accept, double y and launch the multiply, wait, then restore-or-subtract.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    x_d       = x_q;
    y_d       = y_q;
    s_d       = s_q;
    y_out_d   = y_out_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          x_d     = a_bi;
          y_d     = '0;
          s_d     = S_W'(IN_W - 3);
          busy_d  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        y_d       = y_q << 1;
        mul_cnt_d = '0;
        state_d   = ST_MUL;
      end
      ST_MUL: begin
        // The product settles on the same edge mult8 drops busy, i.e. the last counted cycle.
        if (mul_cnt_q == MUL_LAST) begin
          state_d = ST_CHECK;
        end else if (mul_busy) begin
          mul_cnt_d = mul_cnt_q + MUL_CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (take) begin
          x_d = x_q - (t_ext << s_q);
        end
        y_d = y_inc;
        if (s_q == '0) begin
          y_out_d = y_inc;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          s_d     = s_q - S_W'(3);
          state_d = ST_SETUP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and datapath registers; reset drops any run in flight without touching y_bo's reset value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      s_q       <= '0;
      y_out_q   <= '0;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      s_q       <= s_d;
      y_out_q   <= y_out_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign busy_o = busy_q;
  assign y_bo   = y_out_q;

endmodule

// File: tb/tb_cube_root.sv
// Directed checks of cube_root: results scoreboarded against hand-computed roots.
// Latency: each result is also checked for an 80-cycle busy window.
// Backpressure: stimulus waits for idle before each start.
module tb_cube_root;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [23:0] a_bi;
  logic        start_i;
  logic        busy_o;
  logic [7:0]  y_bo;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q[$];

  int          mon_len = 0;
  logic        mon_prev = 1'b0;

  cube_root #(.IN_W(24)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (a_bi),
    .start_i (start_i),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy_o && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    if (busy_o) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy_o still %0d after %0d cycles, expected 0", busy_o, w);
    end
  endtask

  // Issue one start once the unit is idle, pushing the expected root.
  task automatic run(input logic [23:0] a, input logic [7:0] exp_y);
    @(negedge clk_i);
    wait_idle();
    a_bi    = a;
    start_i = 1'b1;
    exp_q.push_back(exp_y);
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  // Monitor: on every falling busy_o, pop and compare the result and the busy length.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        mon_len  = 0;
        mon_prev = 1'b0;
      end else begin
        if (busy_o) begin
          mon_len++;
        end else if (mon_prev) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got %0d, expected no completion", y_bo);
          end else begin
            check("result", y_bo, exp_q.pop_front());
          end
          check("busy_cycles", mon_len, 80);
          mon_len = 0;
        end
        mon_prev = busy_o;
      end
    end
  end

  initial begin
    rst_i   = 1'b0;
    start_i = 1'b0;
    a_bi    = '0;
    repeat (2) @(negedge clk_i);
    check("reset_busy", busy_o, 0);
    check("reset_y", y_bo, 0);
    #2 rst_i = 1'b1;

    run(24'd0,        8'd0);
    run(24'd2097152,  8'd128);
    run(24'd26,       8'd2);
    run(24'd27,       8'd3);
    run(24'd1,        8'd1);
    run(24'd7,        8'd1);
    run(24'd8,        8'd2);
    run(24'd63,       8'd3);
    run(24'd64,       8'd4);
    run(24'd16777215, 8'd255);
    run(24'd16581375, 8'd255);
    run(24'd16581374, 8'd254);

    // Perfect cubes 0..255 back to back
    for (int i = 0; i < 256; i++) begin
      run(24'(i * i * i), 8'(i));
    end

    // Start pulse mid-run with a different operand must be dropped
    run(24'd27, 8'd3);
    repeat (20) @(negedge clk_i);
    a_bi    = 24'hFFFFFF;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    @(negedge clk_i);
    wait_idle();
    repeat (3) @(negedge clk_i);
    check("ignored_start_no_rerun", busy_o, 0);
    check("ignored_start_hold_y", y_bo, 3);

    // Reset mid-run aborts without writing a result
    run(24'd2097152, 8'd128);
    repeat (39) @(negedge clk_i);
    check("abort_pre_busy", busy_o, 1);
    #2 rst_i = 1'b0;
    #1;
    check("abort_busy", busy_o, 0);
    check("abort_y", y_bo, 0);
    void'(exp_q.pop_back());
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    run(24'd26, 8'd2);
    @(negedge clk_i);
    wait_idle();
    repeat (2) @(negedge clk_i);
    check("post_abort_y", y_bo, 2);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
